// File: rtl/recovery_rom_arbiter.sv
// Round-robin arbiter sharing the single-ported recovery ROM between
// NUM_REQ fetch requesters. Grant is combinational; the response (rvalid,
// rdata, range error) comes back one cycle later, in grant order.

// Per-requester address rebasing and ROM window range check.
module rra_lane #(
   parameter logic [31:0] ROM_BASE = 32'h0000_0000,
   parameter int          ROM_SIZE = 32
) (
   input  logic [31:0] addr,
   output logic [31:0] rom_addr,
   output logic        oor
);
   // Window size in bytes, one bit wider so a 4 GiB window cannot wrap.
   localparam logic [32:0] LIMIT = 33'(4 * ROM_SIZE);

   // Offset into the ROM; bits [1:0] pass through untouched.
   assign rom_addr = addr - ROM_BASE;

   // Below the base or at/after the end of the window is a range error.
   assign oor = (addr < ROM_BASE) || ({1'b0, rom_addr} >= LIMIT);
endmodule

module recovery_rom_arbiter #(
   parameter int          NUM_REQ  = 2,
   parameter logic [31:0] ROM_BASE = 32'h0000_0000,
   parameter int          ROM_SIZE = 32
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic [NUM_REQ-1:0]    req_i,
   input  logic [NUM_REQ*32-1:0] addr_i,
   output logic [NUM_REQ-1:0]    gnt_o,
   output logic [NUM_REQ-1:0]    rvalid_o,
   output logic [31:0]           rdata_o,
   output logic                  err_o,
   output logic                  rom_req_o,
   output logic [31:0]           rom_addr_o,
   input  logic [31:0]           rom_rdata_i
);
   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef logic [IDX_W-1:0] idx_t;

   // One-stage response register: who was granted and whether it missed the ROM.
   typedef struct packed {
      logic valid;
      logic err;
      idx_t gidx;
   } rsp_t;

   logic [NUM_REQ-1:0][31:0] lane_addr;
   logic [NUM_REQ-1:0][31:0] lane_rom_addr;
   logic [NUM_REQ-1:0]       lane_oor;

   idx_t rr_q;
   idx_t gidx_d;
   idx_t rr_next;
   logic found;
   rsp_t rsp_q;

   assign lane_addr = addr_i;

   genvar g;
   generate
      for (g = 0; g < NUM_REQ; g++) begin : g_lane
         rra_lane #(
            .ROM_BASE (ROM_BASE),
            .ROM_SIZE (ROM_SIZE)
         ) u_lane (
            .addr     (lane_addr[g]),
            .rom_addr (lane_rom_addr[g]),
            .oor      (lane_oor[g])
         );
      end
   endgenerate

   // Cyclic search for the first active request at or after rr_q.
   always_comb begin
      int   idx;
      idx_t cand;
      gnt_o  = '0;
      gidx_d = '0;
      found  = 1'b0;
      idx    = 0;
      cand   = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         idx = int'(rr_q) + i;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         cand = idx_t'(idx);
         if (!found && req_i[cand]) begin
            found  = 1'b1;
            gidx_d = cand;
         end
      end
      if (found) gnt_o[gidx_d] = 1'b1;
   end

   // Winner's successor becomes top priority next cycle.
   assign rr_next = (gidx_d == idx_t'(NUM_REQ - 1)) ? '0 : gidx_d + idx_t'(1);

   // ROM access is the granted slice, rebased; zero when idle.
   assign rom_req_o  = found;
   assign rom_addr_o = found ? lane_rom_addr[gidx_d] : '0;

   // Pointer update and response capture; reset discards any in-flight read.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rr_q  <= '0;
         rsp_q <= '0;
      end else begin
         if (found) rr_q <= rr_next;
         rsp_q.valid <= found;
         rsp_q.err   <= found & lane_oor[gidx_d];
         rsp_q.gidx  <= gidx_d;
      end
   end

   // Route the ROM data back to the requester granted last cycle.
   always_comb begin
      rvalid_o = '0;
      if (rsp_q.valid) rvalid_o[rsp_q.gidx] = 1'b1;
      rdata_o = (rsp_q.valid && !rsp_q.err) ? rom_rdata_i : '0;
      err_o   = rsp_q.valid & rsp_q.err;
   end

   // Grant and response vectors are never more than one-hot.
   a_gnt_onehot : assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(gnt_o));
   a_rv_onehot  : assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(rvalid_o));
endmodule

// File: tb/tb_recovery_rom_arbiter.sv
// Scoreboard bench: stimulus pushes hand-computed responses, monitors pop
// and compare whenever a DUT raises rvalid. Two instances: 2 requesters
// at base 0, and 3 requesters at base 0x1000.
module tb_recovery_rom_arbiter;
   typedef struct {
      logic [7:0]  rv;
      logic [31:0] d;
      logic        e;
   } exp_t;

   logic clk;
   logic rst_n;

   // Instance A: NUM_REQ=2, ROM_BASE=0
   logic [1:0]  req_a, gnt_a, rvalid_a;
   logic [63:0] addr_a;
   logic [31:0] rdata_a, rom_addr_a, rom_rd_a;
   logic        err_a, rom_req_a;

   // Instance B: NUM_REQ=3, ROM_BASE=0x1000
   logic [2:0]  req_b, gnt_b, rvalid_b;
   logic [95:0] addr_b;
   logic [31:0] rdata_b, rom_addr_b, rom_rd_b;
   logic        err_b, rom_req_b;

   logic [31:0] rom_mem [32];
   exp_t qa[$];
   exp_t qb[$];
   int n_chk = 0;
   int n_err = 0;

   recovery_rom_arbiter #(.NUM_REQ(2), .ROM_BASE(32'h0000_0000), .ROM_SIZE(32)) u_dut_a (
      .clk_i(clk), .rst_ni(rst_n), .req_i(req_a), .addr_i(addr_a),
      .gnt_o(gnt_a), .rvalid_o(rvalid_a), .rdata_o(rdata_a), .err_o(err_a),
      .rom_req_o(rom_req_a), .rom_addr_o(rom_addr_a), .rom_rdata_i(rom_rd_a));

   recovery_rom_arbiter #(.NUM_REQ(3), .ROM_BASE(32'h0000_1000), .ROM_SIZE(32)) u_dut_b (
      .clk_i(clk), .rst_ni(rst_n), .req_i(req_b), .addr_i(addr_b),
      .gnt_o(gnt_b), .rvalid_o(rvalid_b), .rdata_o(rdata_b), .err_o(err_b),
      .rom_req_o(rom_req_b), .rom_addr_o(rom_addr_b), .rom_rdata_i(rom_rd_b));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      for (int i = 0; i < 32; i++) rom_mem[i] = 32'hA500_0000 | 32'(i);
      rom_mem[0] = 32'h0000_0533;
      rom_mem[1] = 32'h0015_0513;
      rom_mem[2] = 32'hffdf_f06f;
      rom_mem[3] = 32'h7b20_0073;
   end

   // 1-cycle-latency ROM models, word indexed.
   always @(posedge clk) begin
      rom_rd_a <= rom_mem[rom_addr_a[6:2]];
      rom_rd_b <= rom_mem[rom_addr_b[6:2]];
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step_a(input logic [1:0] req, input logic [31:0] a0, input logic [31:0] a1,
                         input logic [1:0] eg, input logic [31:0] ed, input logic ee);
      exp_t e;
      logic [31:0] ea;
      @(negedge clk);
      req_a  = req;
      addr_a = {a1, a0};
      #1;
      ea = eg[0] ? a0 : (eg[1] ? a1 : 32'h0);
      check("a_gnt", gnt_a, eg);
      check("a_rom_req", rom_req_a, |eg);
      check("a_rom_addr", rom_addr_a, ea);
      if (eg != 0) begin
         e.rv = 8'(eg); e.d = ed; e.e = ee;
         qa.push_back(e);
      end
   endtask

   task automatic step_b(input logic [2:0] req, input logic [31:0] a0, input logic [31:0] a1,
                         input logic [31:0] a2, input logic [2:0] eg, input logic [31:0] ed,
                         input logic ee);
      exp_t e;
      logic [31:0] ea;
      @(negedge clk);
      req_b  = req;
      addr_b = {a2, a1, a0};
      #1;
      ea = eg[0] ? a0 : (eg[1] ? a1 : (eg[2] ? a2 : 32'h0));
      if (eg != 0) ea = ea - 32'h1000;
      check("b_gnt", gnt_b, eg);
      check("b_rom_req", rom_req_b, |eg);
      check("b_rom_addr", rom_addr_b, ea);
      if (eg != 0) begin
         e.rv = 8'(eg); e.d = ed; e.e = ee;
         qb.push_back(e);
      end
   endtask

   // Response monitors: any rvalid must match the oldest expected entry.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n) begin
         if (rvalid_a != 0) begin
            if (qa.size() == 0) check("a_spurious_rvalid", rvalid_a, 0);
            else begin
               e = qa.pop_front();
               check("a_rvalid", rvalid_a, e.rv);
               check("a_rdata", rdata_a, e.d);
               check("a_err", err_a, e.e);
            end
         end else check("a_idle_out", {err_a, rdata_a}, 0);
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (rst_n) begin
         if (rvalid_b != 0) begin
            if (qb.size() == 0) check("b_spurious_rvalid", rvalid_b, 0);
            else begin
               e = qb.pop_front();
               check("b_rvalid", rvalid_b, e.rv);
               check("b_rdata", rdata_b, e.d);
               check("b_err", err_b, e.e);
            end
         end else check("b_idle_out", {err_b, rdata_b}, 0);
      end
   end

   initial begin
      rst_n = 1'b0;
      req_a = '0; addr_a = '0;
      req_b = '0; addr_b = '0;
      @(negedge clk);
      check("rst_gnt", {gnt_b, gnt_a}, 0);
      check("rst_rvalid", {rvalid_b, rvalid_a}, 0);
      check("rst_rdata", {rdata_b, rdata_a}, 0);
      check("rst_err", {err_b, err_a}, 0);
      check("rst_rom_req", {rom_req_b, rom_req_a}, 0);
      #7 rst_n = 1'b1;

      // Both requesting: strict alternation from index 0.
      for (int i = 0; i < 3; i++) begin
         step_a(2'b11, 32'h4, 32'hC, 2'b01, 32'h0015_0513, 1'b0);
         step_a(2'b11, 32'h4, 32'hC, 2'b10, 32'h7b20_0073, 1'b0);
      end
      // Requester 0 alone, back-to-back.
      step_a(2'b01, 32'h0, 32'h0, 2'b01, 32'h0000_0533, 1'b0);
      step_a(2'b01, 32'h8, 32'h0, 2'b01, 32'hffdf_f06f, 1'b0);
      // Requester 1 alone three times, then both: requester 0 wins.
      for (int i = 0; i < 3; i++) step_a(2'b10, 32'h0, 32'hC, 2'b10, 32'h7b20_0073, 1'b0);
      step_a(2'b11, 32'h4, 32'hC, 2'b01, 32'h0015_0513, 1'b0);
      // Out of range: first byte past the window.
      step_a(2'b10, 32'h0, 32'h80, 2'b10, 32'h0, 1'b1);
      // Grant to 0 leaves rr at 1; idle must keep it there.
      step_a(2'b01, 32'h4, 32'h0, 2'b01, 32'h0015_0513, 1'b0);
      for (int i = 0; i < 5; i++) step_a(2'b00, 32'h0, 32'h0, 2'b00, 32'h0, 1'b0);
      step_a(2'b11, 32'h4, 32'hC, 2'b10, 32'h7b20_0073, 1'b0);
      // Grant to 0 (rr -> 1), then asynchronous reset pulse discards the response.
      step_a(2'b01, 32'h0, 32'h0, 2'b01, 32'h0000_0533, 1'b0);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("rst_pulse_rvalid", rvalid_a, 0);
      check("rst_pulse_rdata", rdata_a, 0);
      qa.delete();
      #1 rst_n = 1'b1;
      step_a(2'b11, 32'h4, 32'hC, 2'b01, 32'h0015_0513, 1'b0);
      // Low address bits pass through.
      step_a(2'b01, 32'h6, 32'h0, 2'b01, 32'h0015_0513, 1'b0);
      step_a(2'b00, 32'h0, 32'h0, 2'b00, 32'h0, 1'b0);

      // Instance B: base 0x1000, three requesters.
      step_b(3'b010, 32'h0, 32'h0FFC, 32'h0, 3'b010, 32'h0, 1'b1);
      step_b(3'b111, 32'h1000, 32'h1004, 32'h1008, 3'b100, 32'hffdf_f06f, 1'b0);
      step_b(3'b111, 32'h1000, 32'h1004, 32'h1008, 3'b001, 32'h0000_0533, 1'b0);
      step_b(3'b111, 32'h1000, 32'h1004, 32'h1008, 3'b010, 32'h0015_0513, 1'b0);
      step_b(3'b001, 32'h107C, 32'h0, 32'h0, 3'b001, 32'hA500_001F, 1'b0);
      step_b(3'b100, 32'h0, 32'h0, 32'h1080, 3'b100, 32'h0, 1'b1);
      for (int i = 0; i < 3; i++) step_b(3'b000, 32'h0, 32'h0, 32'h0, 3'b000, 32'h0, 1'b0);

      @(negedge clk);
      #1;
      check("a_queue_drained", qa.size(), 0);
      check("b_queue_drained", qb.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
